// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic {
    FS_BOOT = 1'b0,
    FS_RUN  = 1'b1
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned PC_INC      = INSTR_BYTES;

endpackage

// File: rtl/fetch_unit_if.sv
// Boot-load, redirect and fetched-instruction bundle between the fetch stage and its neighbours.
interface fetch_unit_if #(
  parameter int unsigned PC_W   = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 8
);

  logic              boot_up;
  logic              boot_web;
  logic [IDX_W-1:0]  boot_addr;
  logic [DATA_W-1:0] boot_datai;
  logic              stall;
  logic              branch_valid;
  logic [PC_W-1:0]   branch_target;
  logic [DATA_W-1:0] instn;
  logic [PC_W-1:0]   instn_pc;
  logic              instn_valid;
  logic              pc_run;
  logic [31:0]       perf_issue_cnt;

  modport master (
    output boot_up, boot_web, boot_addr, boot_datai, stall, branch_valid, branch_target,
    input  instn, instn_pc, instn_valid, pc_run, perf_issue_cnt
  );

  modport slave (
    input  boot_up, boot_web, boot_addr, boot_datai, stall, branch_valid, branch_target,
    output instn, instn_pc, instn_valid, pc_run, perf_issue_cnt
  );

endinterface

// File: rtl/fetch_mem.sv
// Single-port synchronous SRAM model (DEPTH x DATA_W), write when web_i low, registered read.
module fetch_mem #(
  parameter  int unsigned DEPTH  = 256,
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              web_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [DATA_W-1:0] di_i,
  output logic [DATA_W-1:0] do_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Read returns the pre-write contents on a same-address write.
  always_ff @(posedge clk) begin
    if (!web_i) begin
      mem_q[addr_i] <= di_i;
    end
    do_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, boot-loadable instruction memory and BOOT/RUN control.
// Define FETCH_PERF_CNT_EN to build the saturating issued-instruction counter.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W     = 16,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned RESET_PC = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.slave  bus
);

  localparam int unsigned   IDX_W  = $clog2(DEPTH);
  localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC) & ~PC_W'(3);

  fetch_state_e      state_q;
  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   instn_pc_q;
  logic              instn_valid_q;
  logic              pc_run_q;
  logic [IDX_W-1:0]  mem_addr;
  logic              mem_web;
  logic [DATA_W-1:0] mem_rdata;
  logic              unused_tgt_lsbs;

  assign unused_tgt_lsbs = ^bus.branch_target[1:0];

  // Boot owns the port; a stalled valid word is re-read so instn holds.
  always_comb begin
    mem_addr = pc_q[IDX_W+1:2];
    mem_web  = 1'b1;
    if (state_q == FS_BOOT) begin
      mem_addr = bus.boot_addr;
      mem_web  = bus.boot_web;
    end else if (bus.stall && instn_valid_q) begin
      mem_addr = instn_pc_q[IDX_W+1:2];
    end
  end

  fetch_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk    (clk),
    .web_i  (mem_web),
    .addr_i (mem_addr),
    .di_i   (bus.boot_datai),
    .do_o   (mem_rdata)
  );

  // BOOT/RUN controller and PC; in RUN: re-boot > branch > stall > advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FS_BOOT;
      pc_q          <= PC_RST;
      instn_pc_q    <= '0;
      instn_valid_q <= 1'b0;
      pc_run_q      <= 1'b0;
    end else if (state_q == FS_BOOT) begin
      pc_q          <= PC_RST;
      instn_valid_q <= 1'b0;
      if (!bus.boot_up) begin
        state_q  <= FS_RUN;
        pc_run_q <= 1'b1;
      end
    end else if (bus.boot_up) begin
      state_q       <= FS_BOOT;
      pc_run_q      <= 1'b0;
      pc_q          <= PC_RST;
      instn_valid_q <= 1'b0;
    end else if (bus.branch_valid) begin
      pc_q          <= {bus.branch_target[PC_W-1:2], 2'b00};
      instn_valid_q <= 1'b0;
    end else if (!bus.stall) begin
      pc_q          <= pc_q + PC_W'(PC_INC);
      instn_pc_q    <= pc_q;
      instn_valid_q <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_cnt_q;

  // Counts words consumed downstream; saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt_q <= '0;
    end else if ((state_q == FS_RUN) && instn_valid_q && !bus.stall && !bus.branch_valid
                 && (perf_cnt_q != 32'hFFFF_FFFF)) begin
      perf_cnt_q <= perf_cnt_q + 32'd1;
    end
  end

  assign bus.perf_issue_cnt = perf_cnt_q;
`else
  assign bus.perf_issue_cnt = '0;
`endif

  assign bus.instn       = mem_rdata;
  assign bus.instn_pc    = instn_pc_q;
  assign bus.instn_valid = instn_valid_q;
  assign bus.pc_run      = pc_run_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against a cycle-level behavioural model.
module tb_fetch_unit;

  localparam int unsigned PC_W   = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned IDX_W  = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fetch_unit_if #(.PC_W(PC_W), .DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

  fetch_unit #(
    .PC_W     (PC_W),
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .RESET_PC (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference: memory image plus the architecturally visible fetch state.
  logic [31:0] ref_mem [DEPTH];
  bit          m_run;
  bit          m_valid;
  logic [15:0] m_pc;
  logic [15:0] m_ipc;
  logic [31:0] m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_perf();
`ifdef FETCH_PERF_CNT_EN
    return m_cnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    m_run   = 1'b0;
    m_valid = 1'b0;
    m_pc    = 16'h0;
    m_ipc   = 16'h0;
    m_cnt   = 32'd0;
  endtask

  task automatic model_edge(input logic bu, input logic bw, input logic [7:0] ba,
                            input logic [31:0] bd, input logic st, input logic br,
                            input logic [15:0] bt);
    if (!m_run) begin
      if (!bw) ref_mem[ba] = bd;
      m_pc    = 16'h0;
      m_valid = 1'b0;
      if (!bu) m_run = 1'b1;
    end else begin
      if (m_valid && !st && !br && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (bu) begin
        m_run   = 1'b0;
        m_valid = 1'b0;
        m_pc    = 16'h0;
      end else if (br) begin
        m_pc    = bt & 16'hFFFC;
        m_valid = 1'b0;
      end else if (!st) begin
        m_ipc   = m_pc;
        m_pc    = m_pc + 16'd4;
        m_valid = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("pc_run", bus.pc_run, m_run);
    chk("instn_valid", bus.instn_valid, m_valid);
    if (m_valid) begin
      chk("instn_pc", bus.instn_pc, m_ipc);
      chk("instn", bus.instn, ref_mem[(m_ipc >> 2) % DEPTH]);
    end
    chk("perf_issue_cnt", bus.perf_issue_cnt, exp_perf());
  endtask

  // One clock: drive inputs, advance model at the edge, check 1 time unit later.
  task automatic step(input logic bu, input logic bw, input logic [7:0] ba,
                      input logic [31:0] bd, input logic st, input logic br,
                      input logic [15:0] bt);
    bus.boot_up       = bu;
    bus.boot_web      = bw;
    bus.boot_addr     = ba;
    bus.boot_datai    = bd;
    bus.stall         = st;
    bus.branch_valid  = br;
    bus.branch_target = bt;
    @(posedge clk);
    model_edge(bu, bw, ba, bd, st, br, bt);
    #1;
    check_outputs();
  endtask

  task automatic run1(input logic st, input logic br, input logic [15:0] bt);
    step(1'b0, 1'b1, 8'h0, 32'h0, st, br, bt);
  endtask

  initial begin
    logic [31:0] d;
    bus.boot_up       = 1'b1;
    bus.boot_web      = 1'b1;
    bus.boot_addr     = '0;
    bus.boot_datai    = '0;
    bus.stall         = 1'b0;
    bus.branch_valid  = 1'b0;
    bus.branch_target = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc_run", bus.pc_run, 1'b0);
    chk("rst_valid", bus.instn_valid, 1'b0);
    chk("rst_instn_pc", bus.instn_pc, 16'h0);
    chk("rst_perf", bus.perf_issue_cnt, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // Boot image: 11,22,33,44 at words 0..3, FF at the last word, random elsewhere.
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (i < 4)        d = 32'h11 * 32'(i + 1);
      else if (i == 255) d = 32'hFF;
      else              d = $urandom;
      step(1'b1, 1'b0, 8'(i), d, 1'b0, 1'b0, 16'h0);
    end

    step(1'b0, 1'b1, 8'h0, 32'h0, 1'b0, 1'b0, 16'h0);
    chk("e0_pc_run", bus.pc_run, 1'b1);
    chk("e0_valid", bus.instn_valid, 1'b0);
    run1(0, 0, 0);
    chk("s0_instn", bus.instn, 32'h11);
    chk("s0_pc", bus.instn_pc, 16'h0);
    run1(0, 0, 0);
    chk("s1_instn", bus.instn, 32'h22);

    for (int k = 0; k < 3; k++) begin
      run1(1, 0, 0);
      chk("stall_instn", bus.instn, 32'h22);
      chk("stall_pc", bus.instn_pc, 16'h4);
      chk("stall_valid", bus.instn_valid, 1'b1);
    end
    run1(0, 0, 0);
    chk("release_instn", bus.instn, 32'h33);
    chk("release_pc", bus.instn_pc, 16'h8);
    run1(0, 0, 0);

    // Branch squash, then the same with a coincident stall.
    for (int k = 0; k < 2; k++) begin
      run1(0, 1, 16'h4);
      run1(0, 0, 0);
      chk("pre_br_pc", bus.instn_pc, 16'h4);
      run1(logic'(k), 1, 16'h0E);
      chk("br_squash", bus.instn_valid, 1'b0);
      run1(0, 0, 0);
      chk("br_tgt_pc", bus.instn_pc, 16'h0C);
      chk("br_tgt_instn", bus.instn, 32'h44);
    end

    // Memory index aliasing past DEPTH words.
    run1(0, 1, 16'h3FC);
    run1(0, 0, 0);
    chk("wrap_pc0", bus.instn_pc, 16'h3FC);
    chk("wrap_instn0", bus.instn, 32'hFF);
    run1(0, 0, 0);
    chk("wrap_pc1", bus.instn_pc, 16'h400);
    chk("wrap_instn1", bus.instn, 32'h11);

    // Re-boot mid-run with a discarded simultaneous branch.
    step(1'b1, 1'b1, 8'h0, 32'h0, 1'b0, 1'b1, 16'h40);
    chk("reboot_valid", bus.instn_valid, 1'b0);
    chk("reboot_run", bus.pc_run, 1'b0);
    step(1'b1, 1'b0, 8'h0, 32'hAA, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 8'h0, 32'h0, 1'b0, 1'b0, 16'h0);
    run1(0, 0, 0);
    chk("reboot_instn", bus.instn, 32'hAA);
    chk("reboot_pc", bus.instn_pc, 16'h0);

    // Asynchronous reset between edges.
    run1(0, 0, 0);
    run1(0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_run", bus.pc_run, 1'b0);
    chk("arst_valid", bus.instn_valid, 1'b0);
    chk("arst_pc", bus.instn_pc, 16'h0);
    chk("arst_perf", bus.perf_issue_cnt, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // 10 issued words across 2 stalls and 1 branch.
    run1(0, 0, 0);
    run1(0, 0, 0);
    repeat (4) run1(0, 0, 0);
    repeat (2) run1(1, 0, 0);
    repeat (3) run1(0, 0, 0);
    run1(0, 1, 16'h20);
    run1(0, 0, 0);
    repeat (3) run1(0, 0, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_total", bus.perf_issue_cnt, 32'd10);
`else
    chk("perf_total", bus.perf_issue_cnt, 32'd0);
`endif

    // Random phase: fresh image, then mixed stall/branch/re-boot traffic.
    step(1'b1, 1'b1, 8'h0, 32'h0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < int'(DEPTH); i++) begin
      step(1'b1, 1'b0, 8'(i), $urandom, 1'b0, 1'b0, 16'h0);
    end
    for (int i = 0; i < 600; i++) begin
      logic bu;
      bu = m_run ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) != 0);
      step(bu, 1'($urandom_range(0, 1)), 8'($urandom), $urandom,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
